// File: rtl/pc_sequencer.sv
// Program-counter sequencer: variable-length increment, signed relative branch with
// page-cross pulse, absolute jump, and an internal LIFO return stack for call/return.
module pc_sequencer #(
    parameter int unsigned          ADDR_W      = 16,
    parameter int unsigned          OFFS_W      = 8,
    parameter int unsigned          STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0]    RESET_ADDR  = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic [2:0]                         op,
    input  logic [1:0]                         inc_len,
    input  logic [OFFS_W-1:0]                  branch_off,
    input  logic [ADDR_W-1:0]                  jump_addr,
    input  logic                               err_clr,
    output logic [ADDR_W-1:0]                  addr,
    output logic                               page_cross,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stk_count,
    output logic                               stk_full,
    output logic                               stk_empty,
    output logic                               stk_ovf,
    output logic                               stk_unf
);

    localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_HOLD   = 3'b000,
        OP_INC    = 3'b001,
        OP_BRANCH = 3'b010,
        OP_JUMP   = 3'b011,
        OP_CALL   = 3'b100,
        OP_RET    = 3'b101
    } op_e;

    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic              page_cross_q, page_cross_d;
    logic [CNT_W-1:0]  stk_count_q,  stk_count_d;
    logic              stk_ovf_q,    stk_ovf_d;
    logic              stk_unf_q,    stk_unf_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0] stack_d [STACK_DEPTH];

    logic [ADDR_W-1:0] step_addr;
    logic [ADDR_W-1:0] branch_addr;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  top_idx;
    logic              full_c;
    logic              empty_c;

    // Stack status decoded directly from the entry count.
    assign full_c    = (stk_count_q == CNT_W'(STACK_DEPTH));
    assign empty_c   = (stk_count_q == CNT_W'(0));
    assign push_idx  = IDX_W'(stk_count_q);
    assign top_idx   = IDX_W'(stk_count_q - CNT_W'(1));

    // Candidate addresses; arithmetic wraps modulo 2^ADDR_W.
    assign step_addr   = addr_q + ADDR_W'(inc_len);
    assign branch_addr = addr_q + ADDR_W'($signed(branch_off));

    // Next-state decode for PC, stack and sticky error flags.
    always_comb begin
        addr_d       = addr_q;
        page_cross_d = 1'b0;
        stk_count_d  = stk_count_q;
        stk_ovf_d    = stk_ovf_q & ~err_clr;
        stk_unf_d    = stk_unf_q & ~err_clr;
        stack_d      = stack_q;

        if (en) begin
            case (op_e'(op))
                OP_INC: begin
                    addr_d = step_addr;
                end
                OP_BRANCH: begin
                    addr_d       = branch_addr;
                    page_cross_d = (branch_addr[ADDR_W-1:8] != addr_q[ADDR_W-1:8]);
                end
                OP_JUMP: begin
                    addr_d = jump_addr;
                end
                OP_CALL: begin
                    addr_d = jump_addr;
                    if (full_c) begin
                        stk_ovf_d = 1'b1;
                    end else begin
                        stack_d[push_idx] = step_addr;
                        stk_count_d       = stk_count_q + CNT_W'(1);
                    end
                end
                OP_RET: begin
                    if (empty_c) begin
                        stk_unf_d = 1'b1;
                    end else begin
                        addr_d      = stack_q[top_idx];
                        stk_count_d = stk_count_q - CNT_W'(1);
                    end
                end
                default: begin
                    addr_d = addr_q;
                end
            endcase
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q       <= RESET_ADDR;
            page_cross_q <= 1'b0;
            stk_count_q  <= '0;
            stk_ovf_q    <= 1'b0;
            stk_unf_q    <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            page_cross_q <= page_cross_d;
            stk_count_q  <= stk_count_d;
            stk_ovf_q    <= stk_ovf_d;
            stk_unf_q    <= stk_unf_d;
        end
    end

    // Return-stack storage; contents are meaningless after reset so no reset is needed.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign addr       = addr_q;
    assign page_cross = page_cross_q;
    assign stk_count  = stk_count_q;
    assign stk_full   = full_c;
    assign stk_empty  = empty_c;
    assign stk_ovf    = stk_ovf_q;
    assign stk_unf    = stk_unf_q;

endmodule
